// File: rtl/tb_top_pkg.sv
// Shared constants for the APB up/down timer: register map, TCR fields and prescaler periods.
package tb_top_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int TCR_LOAD = 7;
  localparam int TCR_DIR  = 5;
  localparam int TCR_EN   = 4;

  // Writable TCR bits (load, dir, en, cks); the rest are reserved and read 0.
  localparam logic [7:0] TCR_MASK = 8'hB3;

  typedef enum logic [1:0] {
    CKS_2  = 2'b00,
    CKS_4  = 2'b01,
    CKS_8  = 2'b10,
    CKS_16 = 2'b11
  } cks_e;

  localparam int PER_CLK_2  = 2;
  localparam int PER_CLK_4  = 4;
  localparam int PER_CLK_8  = 8;
  localparam int PER_CLK_16 = 16;

  function automatic logic [3:0] term_count(input cks_e cks);
    logic [3:0] tc;
    case (cks)
      CKS_2:   tc = 4'(PER_CLK_2 - 1);
      CKS_4:   tc = 4'(PER_CLK_4 - 1);
      CKS_8:   tc = 4'(PER_CLK_8 - 1);
      default: tc = 4'(PER_CLK_16 - 1);
    endcase
    return tc;
  endfunction

endpackage

// File: rtl/tb_top_if.sv
// APB-style register bus between a CPU bus model (master) and the timer (slave).
interface tb_top_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/tb_top_prescaler.sv
// Tick generator: free-running counter that pulses tick for one pclk at the selected terminal count.
module tb_top_prescaler
  import tb_top_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  input  logic en,
  input  logic clear,
  input  cks_e cks,
  output logic tick
);

  logic [3:0] cnt;
  logic [3:0] term;
  logic       at_term;

  assign term    = term_count(cks);
  assign at_term = (cnt >= term);
  assign tick    = en && !clear && at_term;

  // Restarting from 0 on clear makes the first tick land one full period after (re)start.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clear || !en) begin
      cnt <= '0;
    end else if (at_term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/tb_top.sv
// 8-bit programmable up/down timer with APB register file, prescaled tick and sticky wrap flags.
module tb_top
  import tb_top_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic     pclk,
  input  logic     presetn,
  tb_top_if.slave  apb,
  output logic     tmr_ovf,
  output logic     tmr_udf
);

  localparam logic [DATA_W-1:0] TCR_WMASK = DATA_W'(TCR_MASK);

  logic [DATA_W-1:0] tdr;
  logic [DATA_W-1:0] tcr;
  logic [DATA_W-1:0] tcnt;
  logic [1:0]        flags;
  logic [DATA_W-1:0] rd_mux;

  logic mapped;
  logic wr_en;
  logic tdr_wr;
  logic tcr_wr;
  logic tsr_wr;
  logic cfg_chg;
  logic presc_clear;
  logic tick;
  logic ovf_set;
  logic udf_set;
  logic flag0_clr;
  logic flag1_clr;

  assign mapped = (apb.paddr <= ADDR_W'(ADDR_TCNT));
  assign wr_en  = apb.psel && apb.penable && apb.pwrite && mapped;
  assign tdr_wr = wr_en && (apb.paddr == ADDR_W'(ADDR_TDR));
  assign tcr_wr = wr_en && (apb.paddr == ADDR_W'(ADDR_TCR));
  assign tsr_wr = wr_en && (apb.paddr == ADDR_W'(ADDR_TSR));

  // Any TCR write that alters a control field restarts the prescaler and
  // suppresses a tick on that edge, so a new cks/dir takes a full period.
  assign cfg_chg     = tcr_wr && ((apb.pwdata & TCR_WMASK) != tcr);
  assign presc_clear = !tcr[TCR_EN] || tcr[TCR_LOAD] || cfg_chg;

  tb_top_prescaler u_prescaler (
    .pclk    (pclk),
    .presetn (presetn),
    .en      (tcr[TCR_EN]),
    .clear   (presc_clear),
    .cks     (cks_e'(tcr[1:0])),
    .tick    (tick)
  );

  assign ovf_set   = tick && !tcr[TCR_DIR] && (tcnt == '1);
  assign udf_set   = tick &&  tcr[TCR_DIR] && (tcnt == '0);
  assign flag0_clr = tsr_wr && !apb.pwdata[0];
  assign flag1_clr = tsr_wr && !apb.pwdata[1];

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tdr   <= '0;
      tcr   <= '0;
      tcnt  <= '0;
      flags <= '0;
    end else begin
      if (tdr_wr) tdr <= apb.pwdata;
      if (tcr_wr) tcr <= apb.pwdata & TCR_WMASK;

      if (tcr[TCR_LOAD]) begin
        tcnt <= tdr;
      end else if (tick) begin
        tcnt <= tcr[TCR_DIR] ? (tcnt - 1'b1) : (tcnt + 1'b1);
      end

      // A wrap on the same edge as a clearing write keeps the flag set.
      flags[0] <= ovf_set || (flags[0] && !flag0_clr);
      flags[1] <= udf_set || (flags[1] && !flag1_clr);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (apb.paddr)
      ADDR_W'(ADDR_TDR):  rd_mux = tdr;
      ADDR_W'(ADDR_TCR):  rd_mux = tcr;
      ADDR_W'(ADDR_TSR):  rd_mux = {{(DATA_W-2){1'b0}}, flags};
      ADDR_W'(ADDR_TCNT): rd_mux = tcnt;
      default:            rd_mux = '0;
    endcase
  end

  assign apb.prdata  = (apb.psel && !apb.pwrite) ? rd_mux : '0;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel && apb.penable && !mapped;

  assign tmr_ovf = flags[0];
  assign tmr_udf = flags[1];

endmodule

// File: tb/tb_tb_top.sv
// Bench for the APB timer: bus-model stimulus feeds a scoreboard queue from an elapsed-time reference model.
module tb_tb_top;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic tmr_ovf;
  logic tmr_udf;

  tb_top_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  tb_top #(.ADDR_W(8), .DATA_W(8)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (apb),
    .tmr_ovf (tmr_ovf),
    .tmr_udf (tmr_udf)
  );

  always #5 pclk = ~pclk;

  int edge_cnt = 0;
  always @(posedge pclk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    bit         err;
    logic [1:0] flags;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails  = 0;

  // Reference model: registers plus elapsed-edge accounting for the prescaler phase.
  int m_tdr, m_tcr, m_tsr, m_tcnt, m_phase, model_edge;

  task automatic model_reset();
    m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tcnt = 0; m_phase = 0;
  endtask

  task automatic model_adv(input int n);
    int p, total, t;
    if (n <= 0) return;
    if (m_tcr[7]) begin
      m_tcnt  = m_tdr;
      m_phase = 0;
    end else if (m_tcr[4]) begin
      p       = 2 << m_tcr[1:0];
      total   = m_phase + n;
      t       = total / p;
      m_phase = total % p;
      if (!m_tcr[5]) begin
        if (m_tcnt + t >= 256) m_tsr = m_tsr | 1;
        m_tcnt = (m_tcnt + t) % 256;
      end else begin
        if (t > m_tcnt) m_tsr = m_tsr | 2;
        m_tcnt = (((m_tcnt - t) % 256) + 256) % 256;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic model_write(input int addr, input int data);
    int old_tsr, set;
    old_tsr = m_tsr;
    if (addr == 1 && ((data & 'hB3) != m_tcr)) begin
      if (m_tcr[7]) m_tcnt = m_tdr;
      m_phase = 0;
    end else begin
      model_adv(1);
    end
    set = m_tsr & ~old_tsr;
    case (addr)
      0: m_tdr = data;
      1: m_tcr = data & 'hB3;
      2: m_tsr = (old_tsr & data & 3) | set;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] model_read(input int addr);
    case (addr)
      0: return 8'(m_tdr);
      1: return 8'(m_tcr);
      2: return 8'(m_tsr);
      3: return 8'(m_tcnt);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per access phase presented on the bus.
  always @(negedge pclk) begin
    exp_t e;
    if (apb.psel === 1'b1 && apb.penable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_access: got access expected none");
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_pslverr"}, {7'd0, apb.pslverr}, {7'd0, e.err});
        chk({e.name, "_pready"}, {7'd0, apb.pready}, 8'h01);
        chk({e.name, "_irq"}, {6'd0, tmr_udf, tmr_ovf}, {6'd0, e.flags});
        if (e.is_rd) chk({e.name, "_prdata"}, apb.prdata, e.data);
      end
    end
  end

  task automatic apb_access(input bit wr, input int addr, input int data, input string nm);
    exp_t e;
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr;
    apb.paddr = 8'(addr); apb.pwdata = 8'(data);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    model_adv(edge_cnt - model_edge);
    model_edge = edge_cnt;
    e.is_rd = !wr;
    e.err   = (addr > 3);
    e.flags = 2'(m_tsr);
    e.data  = wr ? 8'h00 : model_read(addr);
    e.name  = nm;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    if (wr) begin
      model_write(addr, data);
      model_edge = edge_cnt;
    end
  endtask

  task automatic wr(input int addr, input int data, input string nm);
    apb_access(1'b1, addr, data, nm);
  endtask

  task automatic rd(input int addr, input string nm);
    apb_access(1'b0, addr, 0, nm);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge pclk); #1;
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    model_reset();
    model_edge = edge_cnt;
  endtask

  initial begin
    int n;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    model_reset();
    model_edge = 0;
    do_reset();

    for (int a = 0; a < 4; a++) rd(a, "reset");

    wr(1, 'h30, "down_en");
    wait_cycles(256 * 2);
    rd(2, "down_tsr");
    wr(2, 'h00, "down_clr");
    rd(2, "down_tsr_clr");

    do_reset();
    n = $urandom_range(0, 255);
    wr(1, 'h30, "pause_en");
    wait_cycles(n * 2);
    wr(1, 'h00, "pause_stop");
    rd(3, "pause_tcnt_a");
    wait_cycles(20);
    rd(3, "pause_tcnt_b");
    wr(1, 'h30, "pause_resume");
    wait_cycles((256 - n) * 2);
    rd(2, "pause_tsr");
    wr(2, 'h00, "pause_clr");
    rd(2, "pause_tsr_clr");

    do_reset();
    wr(0, 'hF0, "up_tdr");
    wr(1, 'h80, "up_load");
    wr(1, 'h11, "up_en");
    wait_cycles(16 * 4);
    rd(3, "up_tcnt");
    rd(2, "up_tsr");

    wr(0, 'h00, "psc_tdr");
    wr(1, 'h80, "psc_load");
    wr(2, 'h00, "psc_clr");
    wr(1, 'h13, "psc_en");
    wait_cycles(10 * 16);
    rd(3, "psc_tcnt");
    rd(2, "psc_tsr");

    rd('h10, "err_rd");
    wr('h10, 'hFF, "err_wr");
    for (int a = 0; a < 4; a++) rd(a, "err_regs");
    wr(1, 'h80, "err_load");
    wr(1, 'h30, "err_down");
    wait_cycles(4);
    wr(2, 'hFF, "err_tsr_ff");
    rd(2, "err_tsr_kept");

    for (int i = 0; i < 150; i++) begin
      int sel, addr;
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        do_reset();
      end else begin
        addr = $urandom_range(0, 9);
        if (addr > 4) addr = addr % 4;
        else if (addr == 4) addr = $urandom_range(4, 255);
        if ($urandom_range(0, 1) == 1) wr(addr, $urandom_range(0, 255), "rnd_wr");
        else rd(addr, "rnd_rd");
        if ($urandom_range(0, 9) == 0) wait_cycles($urandom_range(100, 600));
        else wait_cycles($urandom_range(0, 30));
      end
    end
    for (int a = 0; a < 4; a++) rd(a, "final");

    wait_cycles(4);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
